reg_bank_arbiter: RTL and testbench

Arbitrates two command sources, A (control unit) and B (debug/DMA port), onto a shared bank of N_REGS 16-bit Register instances. It drives their enable, function-select and data inputs from registered outputs, so each accepted command reaches exactly one register one cycle after acceptance. Ownership is round-robin, and a requester may lock the bank for multi-command sequences. The lock is released by the requester or by a timeout watchdog. The block sits between the control sequencer and the register bank.

---
 rtl/reg_bank_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin arbiter with locking between two command
// sources (A, B) driving a shared bank of 16-bit registers.
// Optional lock watchdog is built when REG_ARB_TIMEOUT_EN is defined.
module reg_bank_arbiter #(
  parameter int N_REGS       = 4,
  parameter int LOCK_TIMEOUT = 16,
  parameter int SEL_W        = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqA,
  input  logic              ReqB,
  input  logic              LockA,
  input  logic              LockB,
  input  logic [SEL_W-1:0]  SelA,
  input  logic [SEL_W-1:0]  SelB,
  input  logic [2:0]        FunSelA,
  input  logic [2:0]        FunSelB,
  input  logic [15:0]       DataA,
  input  logic [15:0]       DataB,
  output logic              GntA,
  output logic              GntB,
  output logic [N_REGS-1:0] RegE,
  output logic [2:0]        RegFunSel,
  output logic [15:0]       RegI,
  output logic [1:0]        Owner,
  output logic              Err,
  output logic              Timeout
);

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    LOCK_A = 2'b01,
    LOCK_B = 2'b10
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               rr;          // 0: A favoured, 1: B favoured
  logic               xfer_a;
  logic               xfer_b;
  logic               xfer;
  logic               expire;
  logic [SEL_W-1:0]   cmd_sel;
  logic [2:0]         cmd_fun;
  logic [15:0]        cmd_data;
  logic               cmd_lock;
  logic               out_of_range;

  // One-hot decode of a register index; indices past the bank give zero.
  function automatic logic [N_REGS-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [N_REGS-1:0] v;
    v = {N_REGS{1'b0}};
    for (int i = 0; i < N_REGS; i++) begin
      if (int'(s) == i) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  // Grant generation: depends only on state, RR pointer and requests.
  always_comb begin
    GntA = 1'b0;
    GntB = 1'b0;
    if (Reset) begin
      GntA = 1'b0;
      GntB = 1'b0;
    end else begin
      case (state)
        FREE: begin
          GntA = ReqA & (~ReqB | ~rr);
          GntB = ReqB & (~ReqA | rr);
        end
        LOCK_A:  GntA = ReqA;
        LOCK_B:  GntB = ReqB;
        default: begin
          GntA = 1'b0;
          GntB = 1'b0;
        end
      endcase
    end
  end

  assign xfer_a = ReqA & GntA;
  assign xfer_b = ReqB & GntB;
  assign xfer   = xfer_a | xfer_b;

  // Select the accepted command's fields.
  always_comb begin
    if (xfer_a) begin
      cmd_sel  = SelA;
      cmd_fun  = FunSelA;
      cmd_data = DataA;
      cmd_lock = LockA;
    end else begin
      cmd_sel  = SelB;
      cmd_fun  = FunSelB;
      cmd_data = DataB;
      cmd_lock = LockB;
    end
  end

  assign out_of_range = (int'(cmd_sel) >= N_REGS);

`ifdef REG_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       timeout_q;

  // Expiry: the LOCK_TIMEOUT-th consecutive idle edge while locked.
  assign expire = (state != FREE) && !xfer &&
                  (wd_cnt == 8'(LOCK_TIMEOUT - 1));

  // Watchdog counter: counts idle locked edges, clears on owner transfer.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wd_cnt <= 8'd0;
    end else if ((state == FREE) || xfer || expire) begin
      wd_cnt <= 8'd0;
    end else begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end

  // Timeout pulse shows in the first cycle after a forced release.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
    end
  end

  assign Timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign Timeout = 1'b0;
`endif

  // Next-state logic: a transfer decides the lock, otherwise the watchdog.
  always_comb begin
    state_next = state;
    if (xfer) begin
      if (cmd_lock) begin
        state_next = xfer_a ? LOCK_A : LOCK_B;
      end else begin
        state_next = FREE;
      end
    end else if (expire) begin
      state_next = FREE;
    end else begin
      state_next = state;
    end
  end

  // State and round-robin pointer registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= FREE;
      rr    <= 1'b0;
    end else begin
      state <= state_next;
      if (xfer) begin
        rr <= xfer_a;
      end else begin
        rr <= rr;
      end
    end
  end

  assign Owner = state;

  // Register-bank drive: one-cycle enable per accepted command.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      RegE      <= {N_REGS{1'b0}};
      RegFunSel <= 3'd0;
      RegI      <= 16'd0;
      Err       <= 1'b0;
    end else begin
      RegE <= (xfer && !out_of_range) ? onehot(cmd_sel) : {N_REGS{1'b0}};
      Err  <= xfer & out_of_range;
      if (xfer) begin
        RegFunSel <= cmd_fun;
        RegI      <= cmd_data;
      end else begin
        RegFunSel <= RegFunSel;
        RegI      <= RegI;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter (N_REGS=3, LOCK_TIMEOUT=4):
// directed scenarios followed by random traffic against a behavioural model.
module tb_reg_bank_arbiter;

  localparam int NR  = 3;
  localparam int LTO = 4;

  logic        Clock;
  logic        Reset;
  logic        ReqA, ReqB, LockA, LockB;
  logic [1:0]  SelA, SelB;
  logic [2:0]  FunSelA, FunSelB;
  logic [15:0] DataA, DataB;
  logic        GntA, GntB;
  logic [NR-1:0] RegE;
  logic [2:0]  RegFunSel;
  logic [15:0] RegI;
  logic [1:0]  Owner;
  logic        Err, Timeout;

  int checks = 0;
  int errors = 0;

  // Model state
  int          m_owner;   // 0 free, 1 A locked, 2 B locked
  int          m_last;    // requester served most recently (0 A, 1 B)
  int          m_idle;
  logic [NR-1:0] e_rege;
  logic [2:0]  e_fun;
  logic [15:0] e_i;
  logic        e_err, e_tmo;

  reg_bank_arbiter #(.N_REGS(NR), .LOCK_TIMEOUT(LTO)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqA(ReqA), .ReqB(ReqB), .LockA(LockA), .LockB(LockB),
    .SelA(SelA), .SelB(SelB), .FunSelA(FunSelA), .FunSelB(FunSelB),
    .DataA(DataA), .DataB(DataB), .GntA(GntA), .GntB(GntB),
    .RegE(RegE), .RegFunSel(RegFunSel), .RegI(RegI), .Owner(Owner),
    .Err(Err), .Timeout(Timeout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle with the inputs already applied.
  task automatic cycle();
    logic ea, eb, xa, xb, lk;
    int   sel;
    #1;
    ea = 1'b0; eb = 1'b0;
    if (!Reset) begin
      if (m_owner == 0) begin
        if (ReqA && ReqB) begin
          ea = (m_last == 1);
          eb = (m_last == 0);
        end else begin
          ea = ReqA;
          eb = ReqB;
        end
      end else if (m_owner == 1) begin
        ea = ReqA;
      end else begin
        eb = ReqB;
      end
    end
    check("GntA", 32'(GntA), 32'(ea));
    check("GntB", 32'(GntB), 32'(eb));

    xa = ReqA && ea;
    xb = ReqB && eb;
    if (Reset) begin
      m_owner = 0; m_last = 1; m_idle = 0;
      e_rege = '0; e_fun = 3'd0; e_i = 16'd0; e_err = 1'b0; e_tmo = 1'b0;
    end else begin
      e_rege = '0; e_err = 1'b0; e_tmo = 1'b0;
      if (xa || xb) begin
        sel   = xa ? int'(SelA) : int'(SelB);
        lk    = xa ? LockA : LockB;
        e_fun = xa ? FunSelA : FunSelB;
        e_i   = xa ? DataA : DataB;
        if (sel < NR) e_rege = NR'(1 << sel);
        else          e_err  = 1'b1;
        m_owner = lk ? (xa ? 1 : 2) : 0;
        m_last  = xa ? 0 : 1;
        m_idle  = 0;
      end else if (m_owner != 0) begin
`ifdef REG_ARB_TIMEOUT_EN
        m_idle++;
        if (m_idle == LTO) begin
          m_owner = 0;
          m_idle  = 0;
          e_tmo   = 1'b1;
        end
`endif
      end
    end

    @(posedge Clock);
    #1;
    check("RegE", 32'(RegE), 32'(e_rege));
    check("RegFunSel", 32'(RegFunSel), 32'(e_fun));
    check("RegI", 32'(RegI), 32'(e_i));
    check("Owner", 32'(Owner), 32'(m_owner));
    check("Err", 32'(Err), 32'(e_err));
    check("Timeout", 32'(Timeout), 32'(e_tmo));
  endtask

  task automatic drive(input logic rst, input logic ra, input logic la, input logic [1:0] sa,
                       input logic rb, input logic lb, input logic [1:0] sb);
    Reset = rst;
    ReqA = ra; LockA = la; SelA = sa; FunSelA = 3'($urandom); DataA = 16'($urandom);
    ReqB = rb; LockB = lb; SelB = sb; FunSelB = 3'($urandom); DataB = 16'($urandom);
    cycle();
  endtask

  initial begin
    m_owner = 0; m_last = 1; m_idle = 0;
    e_rege = '0; e_fun = 3'd0; e_i = 16'd0; e_err = 1'b0; e_tmo = 1'b0;

    // Reset
    drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);

    // Single A command with known payload
    Reset = 1'b0;
    ReqA = 1'b1; LockA = 1'b0; SelA = 2'd2; FunSelA = 3'b010; DataA = 16'hBEEF;
    ReqB = 1'b0; LockB = 1'b0; SelB = 2'd0; FunSelB = 3'd0;   DataB = 16'd0;
    cycle();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);

    // Both requesting, no lock: alternating grants
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 2'(i % 3), 1'b1, 1'b0, 2'((i + 1) % 3));

    // A locks, B waits while A issues commands, then A releases
    drive(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) drive(1'b0, (i % 2) == 0, 1'b1, 2'd1, 1'b1, 1'b0, 2'd2);
    drive(1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 2'd2);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1);

    // A locks then idles with B pending (watchdog path when enabled)
    drive(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1);

    // A locks, idles 3 edges, transfers on the 4th edge keeping the lock
    drive(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
    drive(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 2'd0);
    drive(1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 2'd0);

    // Out-of-range Sel from B, then B locks and reset hits mid-lock
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd3);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd3);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
